// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcodes, default widths and FSM encoding shared by alu_share_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int DEFAULT_WIDTH = 17;
  localparam int DEFAULT_OPW   = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHL = 3'b010;
  localparam logic [2:0] OP_SHR = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Ops whose result MSB carries meaning: carry, borrow or shift-out.
  function automatic logic op_sets_flag(input logic [DEFAULT_OPW-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_share_seq_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin grant; the requester not granted last wins ties
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = (valid0 && valid1) ? ~last_grant : valid1;
    grant     = {valid1 & grant_idx, valid0 & ~grant_idx};
  end

endmodule

`default_nettype wire

// File: rtl/alu_share_seq.sv
// ============================================================================
// alu_share_seq : shares one external ALU between two requesters (IDLE/EXEC/RESP)
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_share_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req0_use_acc,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic [OPW-1:0]   req1_op,
  input  logic             req1_use_acc,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             acc_clr,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_flag,
  output logic [WIDTH-1:0] acc,
  output logic             busy
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, data_q, data_d, acc_q, acc_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d, last_q, last_d, flag_q, flag_d;
  logic [1:0]       grant;
  logic             grant_idx;
  logic             idle;
  logic             accept;

  rr_arb2 u_arb (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req0_valid || req1_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is masked by reset so every output reads 0 while reset is held.
  always_comb begin
    idle       = (state_q == ST_IDLE);
    accept     = idle && (req0_valid || req1_valid);
    req0_ready = grant[0] & idle & reset;
    req1_ready = grant[1] & idle & reset;
    rsp_valid  = (state_q == ST_RESP);
    busy       = !idle;
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    op_d   = op_q;
    id_d   = id_q;
    last_d = last_q;
    data_d = data_q;
    flag_d = flag_q;
    acc_d  = acc_q;
    if (accept) begin
      id_d   = grant_idx;
      last_d = grant_idx;
      if (grant_idx) begin
        x_d  = req1_use_acc ? acc_q : req1_x;
        y_d  = req1_y;
        op_d = req1_op;
      end else begin
        x_d  = req0_use_acc ? acc_q : req0_x;
        y_d  = req0_y;
        op_d = req0_op;
      end
    end
    if (state_q == ST_EXEC) begin
      data_d = alu_out;
      flag_d = op_sets_flag(op_q) & alu_out[WIDTH-1];
      acc_d  = alu_out;
    end
    if (acc_clr) acc_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= '0;
      y_q    <= '0;
      op_q   <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      data_q <= '0;
      flag_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      op_q   <= op_d;
      id_q   <= id_d;
      last_q <= last_d;
      data_q <= data_d;
      flag_q <= flag_d;
      acc_q  <= acc_d;
    end
  end

  assign alu_x    = x_q;
  assign alu_y    = y_q;
  assign alu_op   = op_q;
  assign rsp_id   = id_q;
  assign rsp_data = data_q;
  assign rsp_flag = flag_q;
  assign acc      = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_share_seq.sv
// ============================================================================
// tb_alu_share_seq : vector table plus corner sequences, scoreboarded responses
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_seq;

  logic        clk, reset;
  logic        req0_valid, req0_ready, req0_use_acc;
  logic        req1_valid, req1_ready, req1_use_acc;
  logic [16:0] req0_x, req0_y, req1_x, req1_y;
  logic [2:0]  req0_op, req1_op;
  logic [16:0] alu_x, alu_y, alu_out;
  logic [2:0]  alu_op;
  logic        acc_clr, rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
  logic [16:0] rsp_data, acc;

  alu_share_seq dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x),
    .req0_y(req0_y), .req0_op(req0_op), .req0_use_acc(req0_use_acc),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x),
    .req1_y(req1_y), .req1_op(req1_op), .req1_use_acc(req1_use_acc),
    .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .alu_out(alu_out),
    .acc_clr(acc_clr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .acc(acc), .busy(busy)
  );

  // External ALU: shifts move x by one place.
  function automatic logic [16:0] alu_f(input logic [16:0] x, input logic [16:0] y,
                                        input logic [2:0] op);
    case (op)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x << 1;
      3'b011:  return x >> 1;
      3'b100:  return x & y;
      3'b101:  return x | y;
      3'b110:  return x ^ y;
      default: return ~x;
    endcase
  endfunction

  assign alu_out = alu_f(alu_x, alu_y, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [16:0] data;
    logic        flag;
    logic [16:0] acc;
  } sb_t;

  typedef struct {
    logic        id;
    logic [16:0] x;
    logic [16:0] y;
    logic [2:0]  op;
    logic        use_acc;
    logic [16:0] exp_data;
    logic        exp_flag;
  } vec_t;

  sb_t         sbq[$];
  vec_t        vt[11];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [16:0] model_acc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", rsp_valid, 0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_flag", rsp_flag, e.flag);
        chk("rsp_acc", acc, e.acc);
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_req0_ready"}, req0_ready, 0);
    chk({tag, "_req1_ready"}, req1_ready, 0);
    chk({tag, "_alu_x"}, alu_x, 0);
    chk({tag, "_alu_y"}, alu_y, 0);
    chk({tag, "_alu_op"}, alu_op, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_flag"}, rsp_flag, 0);
    chk({tag, "_acc"}, acc, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic drive_req(input logic id, input logic [16:0] x, input logic [16:0] y,
                           input logic [2:0] op, input logic use_acc);
    if (id) begin
      req1_x = x; req1_y = y; req1_op = op; req1_use_acc = use_acc; req1_valid = 1'b1;
    end else begin
      req0_x = x; req0_y = y; req0_op = op; req0_use_acc = use_acc; req0_valid = 1'b1;
    end
  endtask

  // One operation from a single requester; returns one cycle after the EXEC edge.
  task automatic do_op(input logic id, input logic [16:0] x, input logic [16:0] y,
                       input logic [2:0] op, input logic use_acc,
                       input logic [16:0] exp_data, input logic exp_flag, input logic clr);
    logic [16:0] xe;
    bit got;
    drive_req(id, x, y, op, use_acc);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) got = 1;
    end
    chk("accept_timeout", got, 1);
    if (!got) begin
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    xe        = use_acc ? model_acc : x;
    model_acc = clr ? 17'h0 : exp_data;
    sbq.push_back('{id, exp_data, exp_flag, model_acc});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    if (clr) acc_clr = 1'b1;
    chk("exec_busy", busy, 1);
    chk("exec_alu_x", alu_x, xe);
    chk("exec_alu_y", alu_y, y);
    chk("exec_alu_op", alu_op, op);
    chk("exec_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    acc_clr = 1'b0;
    chk("rsp_valid_latency", rsp_valid, 1);
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    chk("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int   acc_cyc[4];
  logic ids[4];

  initial begin
    vt[0]  = '{1'b0, 17'h00001, 17'h0FFFF, 3'b000, 1'b0, 17'h10000, 1'b1};
    vt[1]  = '{1'b1, 17'h00005, 17'h00003, 3'b001, 1'b0, 17'h00002, 1'b0};
    vt[2]  = '{1'b1, 17'h00000, 17'h00002, 3'b010, 1'b1, 17'h00004, 1'b0};
    vt[3]  = '{1'b0, 17'h1FFFF, 17'h1FFFF, 3'b100, 1'b0, 17'h1FFFF, 1'b0};
    vt[4]  = '{1'b0, 17'h00000, 17'h00001, 3'b001, 1'b0, 17'h1FFFF, 1'b1};
    vt[5]  = '{1'b1, 17'h00000, 17'h0F0F0, 3'b110, 1'b1, 17'h10F0F, 1'b0};
    vt[6]  = '{1'b0, 17'h12345, 17'h00000, 3'b011, 1'b0, 17'h091A2, 1'b0};
    vt[7]  = '{1'b1, 17'h00000, 17'h00000, 3'b010, 1'b1, 17'h12344, 1'b1};
    vt[8]  = '{1'b0, 17'h0AAAA, 17'h05555, 3'b101, 1'b0, 17'h0FFFF, 1'b0};
    vt[9]  = '{1'b1, 17'h00F0F, 17'h00000, 3'b111, 1'b0, 17'h1F0F0, 1'b0};
    vt[10] = '{1'b0, 17'h1FFFF, 17'h00001, 3'b000, 1'b0, 17'h00000, 1'b0};

    reset = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_x = 17'h1; req0_y = 17'h1; req0_op = 3'b0; req0_use_acc = 1'b0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_op = '0; req1_use_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    req0_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      do_op(vt[i].id, vt[i].x, vt[i].y, vt[i].op, vt[i].use_acc,
            vt[i].exp_data, vt[i].exp_flag, 1'b0);
      drain();
    end

    // Both requesters held valid straight out of reset: grants alternate 0,1,0,1.
    reset = 1'b0; #2; reset = 1'b1; model_acc = '0;
    @(posedge clk); #1;
    drive_req(1'b0, 17'h00011, 17'h00001, 3'b000, 1'b0);
    drive_req(1'b1, 17'h00020, 17'h00002, 3'b001, 1'b0);
    begin
      int cyc, n;
      cyc = 0; n = 0;
      for (int i = 0; i < 40 && n < 4; i++) begin
        @(negedge clk);
        cyc++;
        if (req0_ready || req1_ready) begin
          chk("alt_exclusive", req0_ready & req1_ready, 0);
          ids[n]     = req1_ready;
          acc_cyc[n] = cyc;
          model_acc  = req1_ready ? 17'h0001E : 17'h00012;
          sbq.push_back('{req1_ready, model_acc, 1'b0, model_acc});
          n++;
        end
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("alt_count", n, 4);
      for (int k = 0; k < n; k++) begin
        logic e;
        e = (k % 2 == 1);
        chk("alt_grant_id", ids[k], e);
        if (k > 0) chk("alt_spacing", acc_cyc[k] - acc_cyc[k-1], 3);
      end
    end
    drain();

    // Consumer stalls the response for four cycles.
    rsp_ready = 1'b0;
    do_op(1'b0, 17'h00003, 17'h00004, 3'b000, 1'b0, 17'h00007, 1'b0, 1'b0);
    drive_req(1'b0, 17'h00009, 17'h00001, 3'b000, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_data", rsp_data, 17'h00007);
      chk("stall_req0_ready", req0_ready, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    do_op(1'b0, 17'h00009, 17'h00001, 3'b000, 1'b0, 17'h0000A, 1'b0, 1'b0);
    drain();

    // Clear during the EXEC load wins over the result; then prove acc really is 0.
    do_op(1'b1, 17'h00007, 17'h00001, 3'b000, 1'b0, 17'h00008, 1'b0, 1'b1);
    drain();
    do_op(1'b0, 17'h1FFFF, 17'h00005, 3'b000, 1'b1, 17'h00005, 1'b0, 1'b0);
    drain();

    // Reset during EXEC aborts; afterwards requester 0 wins a simultaneous request.
    drive_req(1'b0, 17'h00007, 17'h00001, 3'b000, 1'b0);
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        if (req0_ready) got = 1;
      end
      chk("abort_accept", got, 1);
    end
    @(posedge clk); #1;
    drive_req(1'b1, 17'h00100, 17'h00000, 3'b101, 1'b0);
    chk("abort_exec_busy", busy, 1);
    reset = 1'b0;
    #1 check_zero("abort");
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1; model_acc = '0;
    @(negedge clk);
    chk("post_reset_req0_ready", req0_ready, 1);
    chk("post_reset_req1_ready", req1_ready, 0);
    if (req0_ready) sbq.push_back('{1'b0, 17'h00008, 1'b0, 17'h00008});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain();

    chk("sb_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_share_seq.md
Name: alu_share_seq

Overview:
- Controller that shares one combinational 17-bit ALU between two requesters.
- Arbitrates round-robin and latches the winner's operands and opcode.
- Drives the ALU for one cycle and captures the result into a result register and a running accumulator.
- Returns the result to the winner over a valid/ready response channel.
- Sits between the requester-side logic and the ALU instance; the ALU itself stays outside this block.

Parameters:
- WIDTH, 17, datapath width of operands, ALU result and accumulator.
- OPW, 3, opcode width. Bit 2 selects math (0) or logic (1); bits 1:0 select the function.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_x  in  WIDTH  requester 0 operand x.
- req0_y  in  WIDTH  requester 0 operand y.
- req0_op  in  OPW  requester 0 opcode.
- req0_use_acc  in  1  when 1, x is replaced by the accumulator value.
- req1_valid, req1_ready, req1_x, req1_y, req1_op, req1_use_acc: same as requester 0, for requester 1.
- alu_x  out  WIDTH  operand x to the ALU.
- alu_y  out  WIDTH  operand y to the ALU.
- alu_op  out  OPW  opcode to the ALU.
- alu_out  in  WIDTH  combinational ALU result.
- acc_clr  in  1  synchronous accumulator clear.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  index of the requester that owns the response.
- rsp_data  out  WIDTH  captured ALU result.
- rsp_flag  out  1  alu_out[WIDTH-1] for ops 000/001/010 (carry, borrow, shift-out); 0 for all other ops.
- acc  out  WIDTH  current accumulator value.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. All latched operand, result and accumulator registers clear to 0. last_grant is set to 1, so requester 0 wins first. All outputs are 0, including alu_x, alu_y and alu_op.
- Reset asserted mid-operation aborts the operation. No response is produced and the accumulator is not updated.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only one valid requester: it wins. Both valid: the one not equal to last_grant wins.
  - reqN_ready=1 only for the winner, and only in IDLE.
  - On a handshake edge the block latches x, y, op and id. If use_acc=1, the latched x is the acc value at that edge.
  - last_grant is updated to the winner and the FSM moves to EXEC.
  - No valid requester: stay in IDLE.
- EXEC (exactly one cycle):
  - alu_x, alu_y and alu_op are always driven from the latched registers.
  - At the end of the cycle, alu_out is captured into rsp_data and rsp_flag is computed.
  - The accumulator is loaded with alu_out, and the FSM moves to RESP.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_data and rsp_flag held stable until rsp_ready=1.
  - On the handshake edge the FSM moves to IDLE. No new acceptance happens in RESP.
- Latency: accept at edge N, rsp_valid high from edge N+1. With rsp_ready held at 1, the next accept is at edge N+3, giving a peak throughput of 1 op per 3 cycles.
- Arithmetic: the block does no arithmetic of its own; width is WIDTH throughout with no extension or truncation. rsp_flag is taken from the MSB of the result.
- acc_clr clears acc at the next edge. If acc_clr coincides with the EXEC accumulator load, the clear wins, but rsp_data still carries the ALU result.
- Requester stability: a requester that drops valid before being granted is simply not served. Operands are sampled only on the handshake edge.
- busy = (state != IDLE).

Decomposition:
- Shared package alu_pkg holds:
  - Opcode constants OP_ADD=000, OP_SUB=001, OP_SHL=010, OP_SHR=011, OP_AND=100, OP_OR=101, OP_XOR=110, OP_NOT=111.
  - Default WIDTH=17.
  - The FSM state encoding IDLE/EXEC/RESP.
- One sub-module, rr_arb2: a two-way round-robin grant. Inputs are valid0, valid1 and last_grant; outputs are a grant vector and a grant index.

Test Plan:
- Only req0 is valid with x=0x00001, y=0x0FFFF, op=000, and rsp_ready=1 -> req0_ready pulses once; alu_x/alu_y/alu_op show the latched values in EXEC; rsp_valid at N+1 with rsp_data=0x10000, rsp_flag=1, rsp_id=0; acc=0x10000.
- req0 and req1 held valid continuously after reset -> grants alternate 0,1,0,1 on accept edges N, N+3, N+6, N+9.
- req1 issues x=5, y=3, op=001, then use_acc=1, y=0x00002, op=010 -> first rsp_data=0x00002, rsp_flag=0; second rsp_data=0x00004 (2 shifted left), acc=0x00004.
- rsp_ready held 0 for 4 cycles with req0 valid -> rsp_valid and rsp_data stay stable; req0_ready stays 0; busy=1; after rsp_ready=1, return to IDLE and accept.
- acc_clr asserted in the EXEC cycle of x=7, y=1, op=000 -> rsp_data=0x00008 and acc=0.
- reset pulled low during EXEC -> all outputs 0 immediately, no rsp_valid; after release, requester 0 wins a simultaneous request.
